// File: rtl/select_sched.sv
// select_sched: clocked round-robin scheduler in front of a 4-way NCL steering
// select stage. It grants one of four requesters, then issues BURST_LEN
// DATA/NULL four-phase wavefronts on `sel` toward `selectin`. It paces each
// phase on the synchronized `selectinCOMP` completion (`sel_comp`).
// Optional feature macro: SELSCHED_WDOG_EN adds a sticky watchdog on `err`.
// Without that macro, `err` is tied to 0.
module select_sched #(
    parameter int BURST_LEN   = 4,
`ifdef SELSCHED_WDOG_EN
    parameter int TIMEOUT     = 1023,
`endif
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic [3:0] sel,
    input  logic       sel_comp,
    output logic       err
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_NULL
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   comp_s;
    logic [1:0]             ptr, ptr_nxt;
    logic [1:0]             win, win_nxt;
    logic [BEAT_W-1:0]      beat, beat_nxt;
    logic [3:0]             grant_nxt, done_nxt, sel_nxt;
    logic                   any_req;
    logic [1:0]             pick;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Bring the asynchronous completion rail into the clock domain
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sel_comp};
        end
    end

    assign comp_s = sync[SYNC_STAGES-1];

    // Rotating-priority search: the lowest offset from ptr that is requesting wins
    always_comb begin
        any_req = 1'b0;
        pick    = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                any_req = 1'b1;
                pick    = ptr + 2'(k);
            end
        end
    end

    // Next-state and next-output logic for the grant/wavefront sequencer
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        beat_nxt  = beat;
        grant_nxt = grant;
        sel_nxt   = sel;
        done_nxt  = '0;
        unique case (state)
            S_IDLE: begin
                sel_nxt   = '0;
                grant_nxt = '0;
                // A high comp_s means the stage has not yet acknowledged the last NULL
                if (any_req && !comp_s) begin
                    state_nxt = S_DATA;
                    win_nxt   = pick;
                    grant_nxt = onehot(pick);
                    sel_nxt   = onehot(pick);
                    beat_nxt  = '0;
                end
            end
            S_DATA: begin
                sel_nxt = onehot(win);
                if (comp_s) begin
                    state_nxt = S_NULL;
                    sel_nxt   = '0;
                end
            end
            S_NULL: begin
                sel_nxt = '0;
                if (!comp_s) begin
                    if (beat == LAST_BEAT) begin
                        state_nxt = S_IDLE;
                        done_nxt  = onehot(win);
                        grant_nxt = '0;
                        ptr_nxt   = win + 2'd1;
                    end else begin
                        state_nxt = S_DATA;
                        beat_nxt  = beat + 1'b1;
                        sel_nxt   = onehot(win);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                sel_nxt   = '0;
                grant_nxt = '0;
            end
        endcase
    end

    // State and registered outputs; reset forces sel to NULL without a clock
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= S_IDLE;
            ptr   <= '0;
            win   <= '0;
            beat  <= '0;
            grant <= '0;
            sel   <= '0;
            done  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            win   <= win_nxt;
            beat  <= beat_nxt;
            grant <= grant_nxt;
            sel   <= sel_nxt;
            done  <= done_nxt;
        end
    end

`ifdef SELSCHED_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_hit;

    // Fires on the edge where the count in one DATA or NULL phase reaches TIMEOUT
    assign wd_hit = (state_nxt == state) && (state != S_IDLE) &&
                    (wd_cnt == CNT_W'(TIMEOUT - 1));

    // Watchdog only observes the handshake; a stuck NCL phase cannot be safely aborted
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                wd_cnt <= '0;
            end else if ((state != S_IDLE) && (wd_cnt != CNT_W'(TIMEOUT))) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_select_sched.sv
// tb_select_sched: testbench for select_sched. A delay-line stand-in models
// the steering stage's completion. A transaction-level round-robin model
// checks every grant and burst. Directed table vectors and sequences cover
// reset, rotation, mid-burst request drop, asynchronous init, and the
// optional watchdog.
`timescale 1ns/1ps
module tb_select_sched;

    localparam int BL = 4;
    localparam int SS = 2;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    logic        clk    = 1'b0;
    logic        init_n = 1'b0;
    logic [3:0]  req    = 4'b0000;
    logic [3:0]  grant, done, sel;
    logic        sel_comp, err;
    logic [15:0] hist;
    logic [3:0]  req_q;
    logic        stuck0 = 1'b0;
    int          dly    = 5;
    int          total  = 0;
    int          bad    = 0;

    always #5 clk = ~clk;

`ifdef SELSCHED_WDOG_EN
    select_sched #(.BURST_LEN(BL), .TIMEOUT(16), .SYNC_STAGES(SS)) dut (
        .clk(clk), .init_n(init_n), .req(req), .grant(grant), .done(done),
        .sel(sel), .sel_comp(sel_comp), .err(err)
    );
`else
    select_sched #(.BURST_LEN(BL), .SYNC_STAGES(SS)) dut (
        .clk(clk), .init_n(init_n), .req(req), .grant(grant), .done(done),
        .sel(sel), .sel_comp(sel_comp), .err(err)
    );
`endif

    // Steering-stage stand-in: completion follows DATA/NULL on sel, dly cycles later
    always @(posedge clk or negedge init_n) begin
        if (!init_n) hist <= '0;
        else         hist <= {hist[14:0], (sel != 4'b0000)};
    end
    assign sel_comp = stuck0 ? 1'b0 : hist[dly-1];

    // Request value as seen by the DUT at each active edge
    always @(posedge clk) req_q <= req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return 2'((p + k) % 4);
        end
        return p;
    endfunction

    // Transaction-level reference: round-robin winner per grant, BL beats, done on grant fall
    initial begin
        logic [3:0] prev_sel;
        logic [3:0] prev_grant;
        logic [1:0] m_ptr;
        logic [1:0] m_win;
        int         m_beats;
        prev_sel = '0; prev_grant = '0; m_ptr = '0; m_win = '0; m_beats = 0;
        forever begin
            @(negedge clk);
            if (!init_n) begin
                prev_sel = '0; prev_grant = '0; m_ptr = '0; m_beats = 0;
            end else begin
                check("sel_onehot0", 32'($countones(sel) <= 1), 32'd1);
                if (sel != 4'b0000) check("sel_matches_grant", sel, grant);
                if (prev_sel != 4'b0000 && sel != 4'b0000) check("sel_no_data_to_data", sel, prev_sel);
                if (prev_grant == 4'b0000 && grant != 4'b0000) begin
                    m_win = rr_pick(req_q, m_ptr);
                    check("rr_grant", grant, 32'(4'b0001 << m_win));
                    m_beats = 0;
                end else if (prev_grant != 4'b0000 && grant != 4'b0000) begin
                    check("grant_held", grant, prev_grant);
                end
                if (prev_sel == 4'b0000 && sel != 4'b0000) m_beats++;
                if (prev_grant != 4'b0000 && grant == 4'b0000) begin
                    check("done_with_grant_fall", done, prev_grant);
                    check("beats_per_burst", m_beats, BL);
                    m_ptr = m_win + 2'd1;
                end else begin
                    check("done_quiet", done, 32'd0);
                end
`ifndef SELSCHED_WDOG_EN
                check("err_tied", err, 32'd0);
`endif
                prev_sel   = sel;
                prev_grant = grant;
            end
        end
    end

    task automatic wait_grant(output logic [3:0] g);
        int n = 0;
        while (grant == 4'b0000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (grant == 4'b0000) begin
            total++; bad++;
            $display("FAIL grant_timeout: grant=0 after %0d cycles, required nonzero", n);
        end
        g = grant;
    endtask

    // Follows a burst to its done pulse, counting DATA wavefronts; drops req at beat drop_at
    task automatic wait_done(output logic [3:0] d, output int pairs, input int drop_at);
        int         n = 0;
        logic [3:0] ps;
        pairs = (sel != 4'b0000) ? 1 : 0;
        ps    = sel;
        while (done == 4'b0000 && n < 1000) begin
            @(negedge clk);
            n++;
            if (ps == 4'b0000 && sel != 4'b0000) pairs++;
            if (pairs == drop_at) req = 4'b0000;
            ps = sel;
        end
        if (done == 4'b0000) begin
            total++; bad++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required a pulse", n);
        end
        d = done;
    endtask

    task automatic pulse_reset();
        init_n = 1'b0;
        repeat (3) @(negedge clk);
        init_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t       tbl [8];
        logic [3:0] rot [5];
        logic [3:0] g, d;
        int         pairs;

        tbl[0] = '{4'b0100, 4'b0100};
        tbl[1] = '{4'b0011, 4'b0001};
        tbl[2] = '{4'b1001, 4'b1000};
        tbl[3] = '{4'b0110, 4'b0010};
        tbl[4] = '{4'b0011, 4'b0001};
        tbl[5] = '{4'b0001, 4'b0001};
        tbl[6] = '{4'b1111, 4'b0010};
        tbl[7] = '{4'b1010, 4'b1000};
        rot    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset with every requester active
        init_n = 1'b0;
        req    = 4'b1111;
        repeat (3) @(negedge clk);
        check("rst_sel", sel, 32'd0);
        check("rst_grant", grant, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_err", err, 32'd0);
        init_n = 1'b1;
        @(posedge clk); #1;
        check("first_grant", grant, 32'b0001);
        check("first_sel", sel, 32'b0001);

        // Continuous requests rotate the grant with one idle cycle between bursts
        for (int i = 0; i < 5; i++) begin
            wait_done(d, pairs, 0);
            check("rot_done", d, rot[i]);
            check("rot_pairs", pairs, BL);
            if (i < 4) begin
                @(negedge clk);
                check("rot_next_grant", grant, rot[i+1]);
            end else begin
                req = 4'b0000;
            end
        end

        // Table of request patterns against hand-derived round-robin winners
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req;
            wait_grant(g);
            check("tbl_grant", g, tbl[i].exp);
            req = 4'b0000;
            wait_done(d, pairs, 0);
            check("tbl_done", d, tbl[i].exp);
            check("tbl_pairs", pairs, BL);
            check("tbl_sel_null", sel, 32'd0);
            @(negedge clk);
            check("tbl_done_one_cycle", done, 32'd0);
            check("tbl_grant_idle", grant, 32'd0);
        end

        // Requester 1 drops its request during beat 2; the burst still completes
        req = 4'b0010;
        wait_grant(g);
        check("drop_grant", g, 32'b0010);
        wait_done(d, pairs, 2);
        check("drop_done", d, 32'b0010);
        check("drop_pairs", pairs, BL);
        @(negedge clk);

        // Asynchronous init during DATA forces NULL before any clock edge
        req = 4'b0010;
        wait_grant(g);
        check("init_pre_sel", sel, 32'b0010);
        #2 init_n = 1'b0;
        #1;
        check("init_async_sel", sel, 32'd0);
        check("init_async_grant", grant, 32'd0);
        check("init_async_done", done, 32'd0);
        repeat (3) @(negedge clk);
        req    = 4'b1111;
        init_n = 1'b1;
        @(posedge clk); #1;
        check("init_ptr_zero_grant", grant, 32'b0001);
        req = 4'b0000;
        wait_done(d, pairs, 0);
        check("init_after_done", d, 32'b0001);
        @(negedge clk);

`ifdef SELSCHED_WDOG_EN
        // Stuck completion in DATA trips the sticky watchdog after 16 cycles
        init_n = 1'b0;
        stuck0 = 1'b1;
        repeat (2) @(negedge clk);
        req    = 4'b0001;
        init_n = 1'b1;
        wait_grant(g);
        req = 4'b0000;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check("wd_err_low", err, 32'd0);
        end
        @(negedge clk);
        check("wd_err_set", err, 32'd1);
        check("wd_sel_held", sel, 32'b0001);
        repeat (5) @(negedge clk);
        check("wd_err_sticky", err, 32'd1);
        init_n = 1'b0;
        #1;
        check("wd_err_cleared", err, 32'd0);
        stuck0 = 1'b0;
        repeat (2) @(negedge clk);
        init_n = 1'b1;
`endif

        // Randomized requests across several completion delays
        for (int seg = 0; seg < 6; seg++) begin
            int n = 0;
            req = 4'b0000;
            while ((grant != 4'b0000 || hist != 16'h0000) && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("rand_quiesce", 32'(grant == 4'b0000 && hist == 16'h0000), 32'd1);
            dly = int'($urandom_range(1, 8));
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            end
        end
        req = 4'b0000;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/select_sched.md
# select_sched

Clocked round-robin scheduler that shares one 4-way NCL steering select stage among four synchronous requesters. Grants one requester at a time and issues BURST_LEN 1-of-4 select wavefronts (DATA/NULL four-phase) into the select stage's `selectin` rail. Waits for the stage's completion (`selectinCOMP`) through a synchronizer before advancing. Sits at the boundary between clocked control logic and the delay-insensitive steering datapath.

## Interface
- `BURST_LEN`, 4: select wavefronts issued per grant; legal range 1..256.
- `SYNC_STAGES`, 2: flops in the `sel_comp` synchronizer; legal range 2..4.
- `TIMEOUT`, 1023: watchdog limit in cycles; only used with `SELSCHED_WDOG_EN`.

Ports:
- `clk`  input  1  Single clock; all state changes on rising edge.
- `init_n`  input  1  Reset, asynchronous, active-low.
- `req`  input  4  Level requests; bit i = requester i. Sampled only in IDLE.
- `grant`  output  4  One-hot, held for the whole burst; 0 when idle.
- `done`  output  4  One-cycle pulse on the granted bit when the burst's last NULL completes.
- `sel`  output  4  NCL 1-of-4 select to `selectin`; 4'b0000 = NULL.
- `sel_comp`  input  1  Completion from `selectinCOMP`; asynchronous; 1 = DATA accepted / request NULL, 0 = request DATA.
- `err`  output  1  Sticky watchdog flag; constant 0 without `SELSCHED_WDOG_EN`.

## Operation
- `comp_s` = `sel_comp` after SYNC_STAGES flops (synchronizer flops reset to 0).
- Round-robin pointer `ptr` (2 bits, reset 0): winner = first set `req` bit searching ptr, ptr+1, ... mod 4.
- Beat counter `beat`, width clog2(BURST_LEN) (min 1), reset 0.
- States:
  - IDLE: `sel`=0, `grant`=0. If any `req` and `comp_s`==0 -> DATA; latch winner, `grant`=onehot(winner), `sel`=onehot(winner), `beat`=0. If `comp_s`==1, stay IDLE (previous NULL not yet acknowledged).
  - DATA: `sel` held at onehot(winner). If `comp_s`==1 -> NULL, `sel`=0.
  - NULL: `sel`=0. If `comp_s`==0: if `beat`==BURST_LEN-1 -> IDLE, pulse `done[winner]`, clear `grant`, `ptr`=winner+1 mod 4; else `beat`++, -> DATA, `sel`=onehot(winner).
- `sel` never has more than one bit set; it never changes DATA->DATA without an intervening NULL.
- A `req` bit dropping mid-burst is ignored; the burst finishes. A `req` held after `done` competes again at the rotated priority.
- BURST_LEN=1: every grant is DATA, NULL, IDLE.

## Timing
- All outputs registered. Reset values: `sel`=0, `grant`=0, `done`=0, `err`=0, state IDLE, `ptr`=0, `beat`=0.
- `init_n` low mid-burst clears `sel` to NULL asynchronously. The steering stage is re-initialized by its own `init`, and the burst is lost. No `done` is produced.
- Req-to-`sel` latency: 1 cycle (the IDLE edge that sees `req` drives `sel` and `grant`).
- `sel_comp` edge to `sel` response: SYNC_STAGES+1 cycles.
- Minimum wavefront period: 2*(SYNC_STAGES+1) cycles plus the datapath completion delay.
- `done` is asserted in the same cycle that `grant` falls. A new grant can begin on the next edge, giving 1 idle cycle between bursts.

## Configuration
- `SELSCHED_WDOG_EN` defined:
  - A cycle counter reloads on every state entry and counts while in DATA or NULL.
  - Reaching TIMEOUT sets `err`=1. `err` is sticky until `init_n`.
  - The FSM is not altered; the NCL handshake cannot be safely aborted.
- Not defined: no counter logic; `err` is tied 0.

## Test plan
- Reset with `req`=4'b1111 held: `sel`, `grant`, `done`, `err` all 0 while `init_n`=0. First grant is 4'b0001 one cycle after release.
- `req`=4'b0100, BURST_LEN=4, bench models the selectA completion with 5-cycle delay:
  - `sel` shows exactly 4 DATA(4'b0100)/NULL pairs.
  - `done`=4'b0100 for 1 cycle, then `grant`=0.
- `req`=4'b1111 continuously: grants rotate 0001, 0010, 0100, 1000, 0001. No requester is granted twice in a row.
- `req[1]` dropped during beat 2 of its burst: burst still completes 4 beats and `done[1]` pulses.
- `init_n` pulsed low while `sel`=4'b0010 in DATA: `sel` goes to 0 without waiting for a clock edge; state IDLE, `ptr`=0.
- With `SELSCHED_WDOG_EN`, TIMEOUT=16, `sel_comp` stuck at 0 in DATA: `err`=1 exactly 16 cycles after DATA entry; `sel` stays 4'b0001; `err` stays 1 until reset.
